// File: rtl/shift_tx_ctrl.sv
// shift_tx_ctrl: word sequencer for a PISO shift register.
// Loads a word, paces N shifts at DIV clocks per bit, then strobes latch.
module shift_tx_ctrl #(
    parameter int N   = 8,
    parameter int DIV = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] data_in,
    input  logic         data_valid,
    output logic         ready,
    output logic         sr_trigger,
    output logic [1:0]   sr_ctrl,
    output logic [N-1:0] sr_d,
    input  logic         sr_last_tick,
    output logic         sclk,
    output logic         latch,
    output logic         done,
    output logic         sync_err
);

    localparam int DW = $clog2(DIV);
    localparam int BW = $clog2(N);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(DIV / 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        LATCH
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [N-1:0]   hold_reg;
    logic [DW-1:0]  div_cnt;
    logic [BW-1:0]  bit_cnt;
    logic           tick;
    logic           last_bit;

    assign tick     = (state == SHIFT) && (div_cnt == DIV_LAST);
    assign last_bit = (bit_cnt == BIT_LAST);
    assign sr_d     = hold_reg;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Capture the word on the accepted handshake only
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            hold_reg <= '0;
        else if (state == IDLE && data_valid)
            hold_reg <= data_in;
    end

    // Bit-period divider and bit counter, cleared outside SHIFT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (state != SHIFT) begin
            div_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DW'(1);
            if (tick && !last_bit)
                bit_cnt <= bit_cnt + BW'(1);
        end
    end

    // Sticky framing error: last_tick must coincide with the final bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sync_err <= 1'b0;
        else if (tick && (last_bit != sr_last_tick))
            sync_err <= 1'b1;
    end

    // Next-state and output decode
    always_comb begin
        state_nx   = state;
        ready      = 1'b0;
        sr_trigger = 1'b0;
        sr_ctrl    = 2'b00;
        sclk       = 1'b0;
        latch      = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (data_valid) state_nx = LOAD;
            end
            LOAD: begin
                sr_ctrl    = 2'b11;
                sr_trigger = 1'b1;
                state_nx   = SHIFT;
            end
            SHIFT: begin
                sr_ctrl    = 2'b01;
                sr_trigger = tick;
                sclk       = (div_cnt >= DIV_HALF);
                if (tick && last_bit) state_nx = LATCH;
            end
            LATCH: begin
                latch    = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_shift_tx_ctrl.sv
// tb_shift_tx_ctrl: phase-count model of the sequencer plus a shift
// register stand-in; two builds (DIV=4 and DIV=2) run side by side.
module tb_shift_tx_ctrl;

    logic            clk;
    logic            rst;
    logic [1:0][7:0] din;
    logic [1:0]      dv;
    logic [1:0]      rdy, trg, sck, lat, dn, serr, lt;
    logic [1:0][1:0] ctl;
    logic [1:0][7:0] sd;
    logic            lt_kill;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    shift_tx_ctrl #(.N(8), .DIV(4)) u0 (
        .clk(clk), .reset(rst), .data_in(din[0]), .data_valid(dv[0]),
        .ready(rdy[0]), .sr_trigger(trg[0]), .sr_ctrl(ctl[0]),
        .sr_d(sd[0]), .sr_last_tick(lt[0]), .sclk(sck[0]),
        .latch(lat[0]), .done(dn[0]), .sync_err(serr[0])
    );

    shift_tx_ctrl #(.N(8), .DIV(2)) u1 (
        .clk(clk), .reset(rst), .data_in(din[1]), .data_valid(dv[1]),
        .ready(rdy[1]), .sr_trigger(trg[1]), .sr_ctrl(ctl[1]),
        .sr_d(sd[1]), .sr_last_tick(lt[1]), .sclk(sck[1]),
        .latch(lat[1]), .done(dn[1]), .sync_err(serr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int dvof(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    task automatic cmp(input string nm, input int i,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d @cyc %0d: got %0h expected %0h",
                     nm, i, cyc, act, exp);
        end
    endtask

    // Shift register stand-in: load / shift-left, collects serial MSBs
    logic [1:0][7:0] q, rx;
    int scnt [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (trg[i] && ctl[i] == 2'b11) begin
                q[i]    <= sd[i];
                scnt[i] <= 0;
            end else if (trg[i] && ctl[i] == 2'b01) begin
                q[i]    <= {q[i][6:0], 1'b0};
                scnt[i] <= scnt[i] + 1;
                rx[i]   <= {rx[i][6:0], q[i][7]};
            end
        end
    end

    assign lt[0] = lt_kill ? 1'b0 : (scnt[0] == 7);
    assign lt[1] = (scnt[1] == 7);

    // Model: ph = cycles since LOAD (-1 idle); LOAD=0, SHIFT=1..8*D, LATCH=8*D+1
    int              ph [2];
    logic [1:0][7:0] wrd;
    logic [1:0]      err;

    function automatic logic is_tick(input int p, input int d);
        return (p >= 1) && (p <= 8 * d) && ((p - 1) % d == d - 1);
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                ph[i]  <= -1;
                wrd[i] <= '0;
                err[i] <= 1'b0;
            end else if (ph[i] < 0) begin
                if (dv[i]) begin
                    ph[i]  <= 0;
                    wrd[i] <= din[i];
                end
            end else begin
                if (is_tick(ph[i], dvof(i)) &&
                    ((((ph[i] - 1) / dvof(i)) == 7) != lt[i]))
                    err[i] <= 1'b1;
                ph[i] <= (ph[i] == 8 * dvof(i) + 1) ? -1 : ph[i] + 1;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int  p, d;
            logic sh;
            p  = ph[i];
            d  = dvof(i);
            sh = (p >= 1) && (p <= 8 * d);
            cmp("ready", i, rdy[i], p < 0);
            cmp("sr_ctrl", i, ctl[i], p == 0 ? 2'b11 : sh ? 2'b01 : 2'b00);
            cmp("sr_trigger", i, trg[i], p == 0 || is_tick(p, d));
            cmp("sclk", i, sck[i], sh && ((p - 1) % d >= d / 2));
            cmp("latch", i, lat[i], p == 8 * d + 1);
            cmp("done", i, dn[i], p == 8 * d + 1);
            cmp("sr_d", i, sd[i], wrd[i]);
            cmp("sync_err", i, serr[i], err[i]);
            if (p == 8 * d + 1)
                cmp("serial_word", i, rx[i], wrd[i]);
        end
    end

    task automatic send(input int i, input logic [7:0] w, output int tacc);
        @(posedge clk);
        #1;
        din[i] = w;
        dv[i]  = 1'b1;
        tacc   = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rdy[i]) begin
                tacc = cyc;
                break;
            end
        end
        if (tacc < 0) cmp("accept_timeout", i, 0, 1);
        @(posedge clk);
        #1;
        dv[i] = 1'b0;
    endtask

    task automatic wait_latch(input int i, output int t);
        t = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (lat[i]) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) cmp("latch_timeout", i, 0, 1);
    endtask

    task automatic wait_load(input int i, output int t);
        t = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (trg[i] && ctl[i] == 2'b11) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) cmp("load_timeout", i, 0, 1);
    endtask

    initial begin
        int ta, tl, tl1, tl2, n;
        rst     = 1'b1;
        din     = '0;
        dv      = '0;
        lt_kill = 1'b0;
        q       = '0;
        rx      = '0;
        scnt[0] = 0;
        scnt[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        cmp("rst_ready", 0, rdy[0], 1);
        cmp("rst_ctrl", 0, ctl[0], 0);
        cmp("rst_d", 0, sd[0], 0);

        // Single word 0xA5
        send(0, 8'hA5, ta);
        wait_latch(0, tl);
        cmp("a5_latency", 0, tl - ta, 34);
        cmp("a5_stream", 0, rx[0], 8'hA5);
        cmp("a5_sync", 0, serr[0], 0);
        @(negedge clk);
        cmp("a5_ready_back", 0, rdy[0], 1);

        // Back-to-back 0xFF then 0x00 with valid held
        @(posedge clk);
        #1;
        din[0] = 8'hFF;
        dv[0]  = 1'b1;
        wait_load(0, tl1);
        din[0] = 8'h00;
        wait_latch(0, tl);
        cmp("ff_stream", 0, rx[0], 8'hFF);
        wait_load(0, tl2);
        dv[0] = 1'b0;
        cmp("b2b_load_gap", 0, tl2 - tl1, 35);
        wait_latch(0, tl);
        cmp("00_stream", 0, rx[0], 8'h00);

        // 0x3C pulse while 0x81 is shifting must be ignored
        send(0, 8'h81, ta);
        repeat (10) @(posedge clk);
        #1;
        din[0] = 8'h3C;
        dv[0]  = 1'b1;
        @(posedge clk);
        #1;
        dv[0] = 1'b0;
        wait_latch(0, tl);
        cmp("81_stream", 0, rx[0], 8'h81);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (lat[0]) n++;
        end
        cmp("no_extra_latch", 0, n, 0);

        // Missing last_tick sets a sticky error
        lt_kill = 1'b1;
        send(0, 8'h66, ta);
        wait_latch(0, tl);
        cmp("lt_lost_sync", 0, serr[0], 1);
        cmp("lt_lost_stream", 0, rx[0], 8'h66);
        lt_kill = 1'b0;
        send(0, 8'h11, ta);
        wait_latch(0, tl);
        cmp("sync_sticky", 0, serr[0], 1);

        // Async reset after third shift trigger of 0xC3
        send(0, 8'hC3, ta);
        n = 0;
        for (int k = 0; k < 100 && n < 3; k++) begin
            @(negedge clk);
            if (trg[0] && ctl[0] == 2'b01) n++;
        end
        cmp("c3_triggers", 0, n, 3);
        #1;
        rst = 1'b1;
        #1;
        cmp("mid_rst_ready", 0, rdy[0], 1);
        cmp("mid_rst_trig", 0, trg[0], 0);
        cmp("mid_rst_ctrl", 0, ctl[0], 0);
        cmp("mid_rst_d", 0, sd[0], 0);
        cmp("mid_rst_latch", 0, lat[0], 0);
        cmp("mid_rst_sync", 0, serr[0], 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(0, 8'h5A, ta);
        wait_latch(0, tl);
        cmp("5a_latency", 0, tl - ta, 34);
        cmp("5a_stream", 0, rx[0], 8'h5A);

        // DIV=2 build
        send(1, 8'h96, ta);
        wait_latch(1, tl);
        cmp("div2_latency", 1, tl - ta, 18);
        cmp("div2_stream", 1, rx[1], 8'h96);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
